// File: rtl/sram_ctl_pkg.sv
// Shared constants and state encoding for the packet-cache SRAM read controller.
// SRAM_RD_PRIO_EN (optional) adds per-port 3-bit request priority; PRIO_W sizes it.
package sram_ctl_pkg;
  localparam int NUM_PORTS = 16;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 64;
  localparam int LEN_W     = 8;
  localparam int PID_W     = 4;
  localparam int PRIO_W    = 3;

  typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/sram_rd_arbiter_rr_pick.sv
// Combinational round-robin winner search starting at ptr, wrapping at NUM_PORTS-1.
// With SRAM_RD_PRIO_EN the request mask is first narrowed to the highest-priority requesters.
module rr_pick
  import sram_ctl_pkg::*;
(
  input  logic [NUM_PORTS-1:0]        req,
`ifdef SRAM_RD_PRIO_EN
  input  logic [NUM_PORTS*PRIO_W-1:0] prio,
`endif
  input  logic [PID_W-1:0]            ptr,
  output logic [PID_W-1:0]            win,
  output logic                        found
);
  logic [NUM_PORTS-1:0] mask;
  logic [PID_W-1:0]     idx;

`ifdef SRAM_RD_PRIO_EN
  logic [PRIO_W-1:0] top;
  always_comb begin
    top = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (req[i] && prio[i*PRIO_W +: PRIO_W] > top) top = prio[i*PRIO_W +: PRIO_W];
    mask = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      mask[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == top);
  end
`else
  assign mask = req;
`endif

  // NUM_PORTS is a power of two, so the PID_W-bit add wraps the search for free
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + PID_W'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
endmodule

// File: rtl/sram_rd_arbiter.sv
// Round-robin sharing of the packet-cache SRAM read port; streams one packet per grant.
// Optional macro SRAM_RD_PRIO_EN adds req_prio and priority-first arbitration.
module sram_rd_arbiter
  import sram_ctl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_vld,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
`ifdef SRAM_RD_PRIO_EN
  input  logic [NUM_PORTS*PRIO_W-1:0] req_prio,
`endif
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic                        sram_rd_en,
  output logic [ADDR_W-1:0]           sram_rd_addr,
  input  logic [DATA_W-1:0]           sram_rd_data,
  output logic                        out_vld,
  output logic [PID_W-1:0]            out_port,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [DATA_W-1:0]           out_data,
  output logic                        busy
);
  state_t           state;
  logic [PID_W-1:0] ptr, cur_port, win;
  logic             found;
  logic [LEN_W-1:0] remaining, raw_len, win_len;
  logic             iss_sop, iss_eop;

  rr_pick u_pick (
    .req   (req_vld),
`ifdef SRAM_RD_PRIO_EN
    .prio  (req_prio),
`endif
    .ptr   (ptr),
    .win   (win),
    .found (found)
  );

  // A zero-length request still reads one word
  assign raw_len = req_len[win*LEN_W +: LEN_W];
  assign win_len = (raw_len == '0) ? LEN_W'(1) : raw_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cur_port     <= '0;
      remaining    <= '0;
      req_ack      <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      busy         <= 1'b0;
      iss_sop      <= 1'b0;
      iss_eop      <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state        <= BURST;
            req_ack[win] <= 1'b1;
            sram_rd_en   <= 1'b1;
            sram_rd_addr <= req_addr[win*ADDR_W +: ADDR_W];
            busy         <= 1'b1;
            cur_port     <= win;
            remaining    <= win_len;
            ptr          <= (win == PID_W'(NUM_PORTS-1)) ? '0 : win + PID_W'(1);
            iss_sop      <= 1'b1;
            iss_eop      <= (win_len == LEN_W'(1));
          end else begin
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            busy         <= 1'b0;
            iss_sop      <= 1'b0;
            iss_eop      <= 1'b0;
          end
        end
        BURST: begin
          iss_sop <= 1'b0;
          if (remaining > LEN_W'(1)) begin
            sram_rd_addr <= sram_rd_addr + ADDR_W'(1);
            remaining    <= remaining - LEN_W'(1);
            iss_eop      <= (remaining == LEN_W'(2));
          end else begin
            // Last read was issued this cycle; the idle cycle that follows is the bubble
            state        <= IDLE;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            busy         <= 1'b0;
            iss_eop      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_port <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
    end else begin
      out_vld  <= sram_rd_en;
      out_port <= cur_port;
      out_sop  <= iss_sop;
      out_eop  <= iss_eop;
    end
  end

  assign out_data = sram_rd_data;
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Self-checking bench: a per-scenario timeline model derived from the arbitration rules
// predicts every cycle of acks, reads and returned words; stimulus mixes directed and $urandom.
module tb_sram_rd_arbiter;
  import sram_ctl_pkg::*;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_PORTS-1:0]        req_vld  = '0;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr = '0;
  logic [NUM_PORTS*LEN_W-1:0]  req_len  = '0;
`ifdef SRAM_RD_PRIO_EN
  logic [NUM_PORTS*PRIO_W-1:0] req_prio = '0;
`endif
  logic [NUM_PORTS-1:0] req_ack;
  logic                 sram_rd_en;
  logic [ADDR_W-1:0]    sram_rd_addr;
  logic [DATA_W-1:0]    sram_rd_data;
  logic                 out_vld, out_sop, out_eop, busy;
  logic [PID_W-1:0]     out_port;
  logic [DATA_W-1:0]    out_data;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;

  logic [NUM_PORTS-1:0] e_ack  [MAXC];
  logic                 e_en   [MAXC];
  logic                 e_sop  [MAXC];
  logic                 e_eop  [MAXC];
  logic [ADDR_W-1:0]    e_addr [MAXC];
  logic [PID_W-1:0]     e_port [MAXC];

  sram_rd_arbiter dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len),
`ifdef SRAM_RD_PRIO_EN
    .req_prio(req_prio),
`endif
    .req_ack(req_ack), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .out_vld(out_vld), .out_port(out_port),
    .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 12'h5A5, 28'hC0FFEE0};
  endfunction

  // SRAM model: one-cycle read latency
  always @(posedge clk) sram_rd_data <= sram_rd_en ? mem_f(sram_rd_addr) : '0;

  function automatic int prio_of(input int i);
`ifdef SRAM_RD_PRIO_EN
    return int'(req_prio[i*PRIO_W +: PRIO_W]);
`else
    return 0;
`endif
  endfunction

  // Highest priority wins; scanning upward from the pointer keeps the first of equals
  function automatic int pick(input logic [NUM_PORTS-1:0] p);
    int best = -1;
    int bp = -1;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int i;
      i = (ptr_m + k) % NUM_PORTS;
      if (p[i] && prio_of(i) > bp) begin
        bp = prio_of(i);
        best = i;
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          input int pr);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W]    = l;
`ifdef SRAM_RD_PRIO_EN
    req_prio[i*PRIO_W +: PRIO_W] = PRIO_W'(pr);
`else
    if (pr < 0) $display("note: negative priority ignored");
`endif
  endtask

  task automatic check_cycle(input int n);
    chk("req_ack", 64'(req_ack), 64'(e_ack[n]));
    chk("rd_en", 64'(sram_rd_en), 64'(e_en[n]));
    chk("busy", 64'(busy), 64'(e_en[n]));
    if (e_en[n]) chk("rd_addr", 64'(sram_rd_addr), 64'(e_addr[n]));
    chk("out_vld", 64'(out_vld), 64'(e_en[n-1]));
    if (e_en[n-1]) begin
      chk("out_port", 64'(out_port), 64'(e_port[n-1]));
      chk("out_sop", 64'(out_sop), 64'(e_sop[n-1]));
      chk("out_eop", 64'(out_eop), 64'(e_eop[n-1]));
      chk("out_data", out_data, mem_f(e_addr[n-1]));
    end
  endtask

  // Requests in mask are all presented at once from an idle arbiter. Bursts follow
  // back to back with one bubble; stop_at>0 ends the run early (for the reset test).
  task automatic run_scn(input logic [NUM_PORTS-1:0] mask, input int stop_at);
    logic [NUM_PORTS-1:0] pend;
    int t, w, len, last;
    pend = mask;
    t = 1;
    for (int c = 0; c < MAXC; c++) begin
      e_ack[c] = '0; e_en[c] = 1'b0; e_sop[c] = 1'b0; e_eop[c] = 1'b0;
      e_addr[c] = '0; e_port[c] = '0;
    end
    while (pend != '0) begin
      w = pick(pend);
      len = (req_len[w*LEN_W +: LEN_W] == '0) ? 1 : int'(req_len[w*LEN_W +: LEN_W]);
      e_ack[t][w] = 1'b1;
      for (int k = 0; k < len; k++) begin
        e_en[t+k]   = 1'b1;
        e_addr[t+k] = req_addr[w*ADDR_W +: ADDR_W] + ADDR_W'(k);
        e_port[t+k] = PID_W'(w);
        e_sop[t+k]  = (k == 0);
        e_eop[t+k]  = (k == len - 1);
      end
      pend[w] = 1'b0;
      ptr_m = (w + 1) % NUM_PORTS;
      t += len + 1;
    end
    last = (stop_at > 0) ? stop_at : t;
    req_vld = mask;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(n);
      req_vld = req_vld & ~req_ack;
    end
  endtask

  initial begin
    logic [NUM_PORTS-1:0] m;
    logic [ADDR_W-1:0] a;

    #1;
    chk("rst_en", 64'(sram_rd_en), 64'(0));
    chk("rst_addr", 64'(sram_rd_addr), 64'(0));
    chk("rst_ack", 64'(req_ack), 64'(0));
    chk("rst_vld", 64'(out_vld), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sopeop", {62'd0, out_sop, out_eop}, 64'(0));
    chk("rst_port", 64'(out_port), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Ports 0, 5, 15 single words, then 15 and 0 together to show the pointer wrapped to 0
    set_port(0, 12'h010, 8'd1, 0); set_port(5, 12'h050, 8'd1, 0); set_port(15, 12'h0F0, 8'd1, 0);
    run_scn(16'h8021, 0);
    run_scn(16'h8001, 0);

    set_port(3, 12'h100, 8'd4, 0);
    run_scn(16'h0008, 0);
    set_port(7, 12'hFFE, 8'd4, 0);
    run_scn(16'h0080, 0);
    set_port(2, 12'h2A0, 8'd0, 0);
    run_scn(16'h0004, 0);

`ifdef SRAM_RD_PRIO_EN
    set_port(1, 12'h111, 8'd2, 2); set_port(9, 12'h999, 8'd2, 6);
    run_scn(16'h0202, 0);
`endif

    for (int it = 0; it < 24; it++) begin
      m = NUM_PORTS'($urandom) & NUM_PORTS'($urandom);
      if (m == '0) m[$urandom_range(0, NUM_PORTS-1)] = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        a = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFC + $urandom_range(0, 3))
                                          : ADDR_W'($urandom);
        set_port(i, a, LEN_W'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
      end
      run_scn(m, 0);
    end

    // Abort a 6-word burst on its second word, then replay it
    set_port(4, 12'h200, 8'd6, 0);
    run_scn(16'h0010, 2);
    rst = 1'b0;
    #1;
    chk("abort_en", 64'(sram_rd_en), 64'(0));
    chk("abort_addr", 64'(sram_rd_addr), 64'(0));
    chk("abort_vld", 64'(out_vld), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_sopeop", {62'd0, out_sop, out_eop}, 64'(0));
    req_vld = '0;
    ptr_m = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_hold_vld", 64'(out_vld), 64'(0));
      chk("abort_hold_en", 64'(sram_rd_en), 64'(0));
    end
    rst = 1'b1;
    run_scn(16'h0010, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_rd_arbiter.md
Name: sram_rd_arbiter

Overview:
- Shares the single SRAM read port of the packet cache among NUM_PORTS output-port read requesters.
- Each requester hands over a start address and a word count (one packet) from cache_manager's per-port read path.
- The arbiter grants one port at a time round-robin and streams that packet's words with incrementing addresses.
- Read data returns tagged with the port id plus sop/eop.

Parameters:
NUM_PORTS, 16, number of requesting output ports
ADDR_W, 12, SRAM word address width
DATA_W, 64, SRAM data width
LEN_W, 8, packet length field width (words)
PID_W, 4, port id width, equals clog2(NUM_PORTS)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_vld  in  NUM_PORTS  per-port read request pending
req_addr  in  NUM_PORTS*ADDR_W  per-port packet start address, port i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_PORTS*LEN_W  per-port packet length in words, port i at [i*LEN_W +: LEN_W]
req_ack  out  NUM_PORTS  one-cycle pulse, request of port i accepted
sram_rd_en  out  1  SRAM read enable
sram_rd_addr  out  ADDR_W  SRAM read address
sram_rd_data  in  DATA_W  SRAM read data, valid 1 cycle after sram_rd_en
out_vld  out  1  returned word valid
out_port  out  PID_W  destination port of returned word
out_sop  out  1  first word of packet
out_eop  out  1  last word of packet
out_data  out  DATA_W  returned word (sram_rd_data passed through)
busy  out  1  burst in progress

Behaviour:
- Reset (rst=0, async) values:
  - req_ack=0, sram_rd_en=0, sram_rd_addr=0, out_vld/out_sop/out_eop=0, out_port=0, busy=0.
  - RR pointer=0; state IDLE.
- State machine: IDLE, BURST.
- IDLE, cycle T, any req_vld set:
  - Winner w is the first set bit searching upward from RR pointer, wrapping at NUM_PORTS-1 -> 0.
  - At T+1: state=BURST, req_ack[w]=1 (single cycle), sram_rd_en=1, sram_rd_addr=req_addr[w], busy=1.
  - Latched: cur_port=w, remaining=req_len[w]; RR pointer=(w+1) mod NUM_PORTS.
  - No request pending: remain IDLE, all outputs low.
- BURST:
  - Each cycle with remaining>1: sram_rd_en=1, sram_rd_addr+=1 modulo 2^ADDR_W (wraps 0xFFF->0x000), remaining-=1.
  - remaining==1 cycle is the last read; next cycle state=IDLE, sram_rd_en=0, busy=0.
  - One idle bubble cycle separates consecutive bursts.
- req_len=0 treated as 1 (single-word packet).
- Requester handshake:
  - A requester holds req_vld/req_addr/req_len stable until req_ack.
  - After ack it may present the next packet the following cycle.
  - req_vld values sampled during BURST are ignored until IDLE.
- Return pipeline, one-cycle registered copy of the read-issue signals:
  - out_vld = sram_rd_en delayed 1.
  - out_port = cur_port delayed 1.
  - out_sop marks the first read of the burst, delayed 1.
  - out_eop marks the last read of the burst, delayed 1.
  - out_data = sram_rd_data combinationally.
  - Single-word packet: out_sop=out_eop=1 on the same cycle.
- Deassertion of req_vld by a granted port mid-burst has no effect; the burst completes.
- Reset mid-burst aborts immediately. In-flight return word is dropped (out_vld=0). Requester must re-request.

Optional Feature:
- Macro SRAM_RD_PRIO_EN.
- Defined:
  - Adds input req_prio, width NUM_PORTS*3 (3-bit priority per port, 7 highest).
  - Winner is a requester with the highest priority among req_vld; ties broken round-robin from RR pointer.
- Undefined: port absent; pure round-robin.

Decomposition:
- Shared package sram_ctl_pkg holds:
  - Constants NUM_PORTS, ADDR_W, DATA_W, LEN_W, PID_W.
  - State enum {IDLE, BURST}.
- One sub-module rr_pick:
  - Combinational round-robin first-set search over req mask from pointer; returns winner index and found flag.
  - With SRAM_RD_PRIO_EN the mask is pre-filtered to the highest-priority requesters.

Test Plan:
- Single request port 3, addr 0x100, len 4:
  - T+1: req_ack[3]=1; sram_rd_addr 0x100..0x103 on 4 consecutive cycles.
  - out_vld 4 cycles later by 1; out_sop on first, out_eop on fourth, out_port=3.
- Ports 0, 5, 15 request simultaneously with pointer 0, each len 1:
  - Grants in order 0, 5, 15, each separated by IDLE bubble.
  - Final pointer=0 (wrapped after 15).
- Port 7, addr 0xFFE, len 4: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Port 2 len 0: one read issued; out_sop=out_eop=1 same cycle.
- rst low during word 2 of a 6-word burst:
  - All outputs 0 asynchronously; no further out_vld.
  - After release, re-request of the same packet replays from its start address.
- SRAM_RD_PRIO_EN, port 1 prio 2 and port 9 prio 6 simultaneously: port 9 granted first, then port 1.
